// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: mult/div latencies, the mult/div
// unit state encoding and the countdown preload helper.
package mips_pkg;

    localparam int MD_MUL_LAT = 4;
    localparam int MD_DIV_LAT = 32;
    localparam int MD_CNT_W   = 6;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Countdown preload: the unit stays busy for LAT cycles, so the counter
    // starts at LAT-1 and the last busy cycle is the one where it reads zero.
    function automatic logic [MD_CNT_W-1:0] md_cnt_init(input logic is_div);
        logic [MD_CNT_W-1:0] val;
        if (is_div) begin
            val = MD_CNT_W'(MD_DIV_LAT - 1);
        end else begin
            val = MD_CNT_W'(MD_MUL_LAT - 1);
        end
        return val;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// md_timer: mult/div occupancy timer (IDLE / MD_BUSY plus a down-counter).
// Only built when HAZARD_CTRL_MD_EN is defined; without it the hazard
// controller has no mult/div tracking at all.
`ifdef HAZARD_CTRL_MD_EN
module md_timer
    import mips_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    md_state_e           state_q;
    md_state_e           state_d;
    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;

    // State and countdown registers; reset clears them immediately, even mid-countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            md_cnt_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next state: issue loads the counter, busy counts down; a new start while busy is ignored.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    md_cnt_d = md_cnt_init(md_div);
                    state_d  = MD_BUSY;
                end else begin
                    md_cnt_d = md_cnt_q;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q == 6'd0) begin
                    state_d = IDLE;
                end else begin
                    md_cnt_d = md_cnt_q - 6'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = 6'd0;
            end
        endcase
    end

    // Busy flag is a direct decode of the state flop, so it is glitch-free.
    always_comb begin
        md_busy = (state_q == MD_BUSY);
    end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/bubble generation for the 5-stage MIPS.
// Handles load-use hazards, taken-branch flushes and (optionally, with
// HAZARD_CTRL_MD_EN defined) mult/div unit occupancy via md_timer.
module hazard_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       branch_taken,
    input  logic       md_start,
    input  logic       md_div,
    input  logic       id_md_use,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       md_busy
);

    logic load_use_s;
    logic md_hold_s;

`ifdef HAZARD_CTRL_MD_EN
    md_timer u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_div   (md_div),
        .md_busy  (md_busy)
    );

    // An instruction touching HI/LO or the unit must wait while the unit is
    // occupied, including the cycle the operation is being issued.
    assign md_hold_s = (md_busy | md_start) & id_md_use;
`else
    logic unused_md_s;
    assign unused_md_s = md_start ^ md_div ^ id_md_use;
    assign md_busy     = 1'b0;
    assign md_hold_s   = 1'b0;
`endif

    // Load-use detection; $zero is never a real dependency.
    always_comb begin
        load_use_s = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    // Pipeline control: branch flush wins over any stall; all quiet during reset.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (reset) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use_s || md_hold_s) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            idex_bubble = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. A cycle-level model (remaining busy
// cycles as a plain integer) is compared against the DUT on every falling
// edge; directed steps add literal checks. Mult/div sections follow
// HAZARD_CTRL_MD_EN.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, branch_taken;
    logic       md_start, md_div, id_md_use;
    logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, md_busy;

    int errors = 0;
    int checks = 0;
    int rem    = 0;

`ifdef HAZARD_CTRL_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    wire [3:0] pipe = {pc_stall, ifid_stall, ifid_flush, idex_bubble};

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .md_div       (md_div),
        .id_md_use    (id_md_use),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .md_busy      (md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Model: number of busy cycles still owed by the mult/div unit.
    always @(posedge clk or posedge reset) begin
        if (reset)                  rem <= 0;
        else if (rem > 0)           rem <= rem - 1;
        else if (MD_EN && md_start) rem <= md_div ? 32 : 4;
    end

    // Compare process: expected controls derived from the hazard rules.
    always @(negedge clk) begin
        logic       lu, hold;
        logic [3:0] exp;
        lu   = ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        hold = MD_EN && ((rem > 0) || md_start) && id_md_use;
        if (reset)             exp = 4'b0000;
        else if (branch_taken) exp = 4'b0011;
        else if (lu || hold)   exp = 4'b1101;
        else                   exp = 4'b0000;
        chk("model_pipe", {28'd0, pipe}, {28'd0, exp});
        chk("model_busy", {31'd0, md_busy}, {31'd0, (MD_EN && rem > 0)});
    end

    initial begin
        int busy_cnt;
        int guard;
        reset = 1'b1; id_rt = 5'd0; id_uses_rt = 1'b0; branch_taken = 1'b0;
        md_start = 1'b0; md_div = 1'b0; id_md_use = 1'b0;
        // Hazard present while reset held: controls must stay low.
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        @(negedge clk);
        chk("reset_pipe", {28'd0, pipe}, 32'd0);
        chk("reset_busy", {31'd0, md_busy}, 32'd0);
        next(); reset = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;
        @(negedge clk);
        chk("idle_pipe", {28'd0, pipe}, 32'd0);

        // Load-use on rs: stall one cycle, released when the load moves on.
        next(); ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        @(negedge clk); chk("load_use_rs", {28'd0, pipe}, 32'hD);
        next(); ex_memread = 1'b0;
        @(negedge clk); chk("load_use_release", {28'd0, pipe}, 32'h0);

        // Load-use on rt only counts when rt is a source.
        next(); ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
        @(negedge clk); chk("load_use_rt", {28'd0, pipe}, 32'hD);
        next(); id_uses_rt = 1'b0;
        @(negedge clk); chk("rt_not_source", {28'd0, pipe}, 32'h0);

        // $zero destination never stalls.
        next(); ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        @(negedge clk); chk("zero_reg", {28'd0, pipe}, 32'h0);

        // Branch beats load-use.
        next(); ex_rt = 5'd9; id_rs = 5'd9; branch_taken = 1'b1;
        @(negedge clk); chk("branch_over_lu", {28'd0, pipe}, 32'h3);
        next(); ex_memread = 1'b0; id_uses_rt = 1'b0;
        @(negedge clk); chk("branch_alone", {28'd0, pipe}, 32'h3);
        next(); branch_taken = 1'b0;
        @(negedge clk); chk("branch_release", {28'd0, pipe}, 32'h0);

`ifdef HAZARD_CTRL_MD_EN
        // Divide with a dependent instruction waiting in ID.
        next(); md_start = 1'b1; md_div = 1'b1; id_md_use = 1'b1;
        @(negedge clk);
        chk("div_start_stall", {28'd0, pipe}, 32'hD);
        chk("div_start_busy", {31'd0, md_busy}, 32'd0);
        next(); md_start = 1'b0;
        busy_cnt = 0; guard = 0;
        @(negedge clk);
        while (md_busy === 1'b1 && guard < 100) begin
            busy_cnt++; guard++;
            chk("div_busy_stall", {28'd0, pipe}, 32'hD);
            @(negedge clk);
        end
        chk("div_busy_len", busy_cnt, 32'd32);
        chk("div_release", {28'd0, pipe}, 32'h0);

        // Multiply; a second start and a branch during busy must not disturb the count.
        next(); id_md_use = 1'b0; md_start = 1'b1; md_div = 1'b0;
        next(); md_start = 1'b1; md_div = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        chk("mul_branch_pipe", {28'd0, pipe}, 32'h3);
        chk("mul_branch_busy", {31'd0, md_busy}, 32'd1);
        next(); md_start = 1'b0; branch_taken = 1'b0;
        busy_cnt = 0; guard = 0;
        @(negedge clk);
        while (md_busy === 1'b1 && guard < 100) begin
            busy_cnt++; guard++;
            @(negedge clk);
        end
        chk("mul_busy_rest", busy_cnt, 32'd3);

        // Reset mid-countdown clears busy at once; no stall afterwards.
        next(); md_start = 1'b1; md_div = 1'b0; id_md_use = 1'b1;
        next(); md_start = 1'b0;
        next(); #2; reset = 1'b1; #1;
        chk("rst_busy_async", {31'd0, md_busy}, 32'd0);
        chk("rst_pipe", {28'd0, pipe}, 32'h0);
        next(); reset = 1'b0;
        @(negedge clk);
        chk("post_rst_pipe", {28'd0, pipe}, 32'h0);
        chk("post_rst_busy", {31'd0, md_busy}, 32'd0);
        next(); id_md_use = 1'b0;
`else
        // Mult/div tracking absent: starts and dependent uses are ignored.
        next(); md_start = 1'b1; md_div = 1'b1; id_md_use = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nomd_pipe", {28'd0, pipe}, 32'h0);
            chk("nomd_busy", {31'd0, md_busy}, 32'd0);
        end
        next(); md_start = 1'b0; id_md_use = 1'b0;
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
